// File: rtl/irq_svc_master.sv
// Wishbone master servicing a timer/interrupt slave: load counter, wait for irq, read status, clear, repeat.
// All outputs registered; each bus access is single-beat with an abort after TIMEOUT unacknowledged strobe cycles.
module irq_svc_master #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] period_i,
  input  logic [7:0] count_i,
  output logic       wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  input  logic       irq_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] irq_cnt_o
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_IRQ, READ, CLEAR, DONE, ERR} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     r_state, w_state;
  logic       r_adr, w_adr;
  logic [7:0] r_dat, w_dat;
  logic       r_we, w_we;
  logic       r_cyc, w_cyc;
  logic       r_stb, w_stb;
  logic       r_busy, w_busy;
  logic       r_done, w_done;
  logic       r_err, w_err;
  logic [7:0] r_cnt, w_cnt;
  logic [7:0] r_to, w_to;
  logic [7:0] r_period, w_period;
  logic [7:0] r_count, w_count;
  logic [7:0] w_cnt_inc;
  logic       w_unused;

  // Only the pending bit of the status register matters.
  assign w_unused  = ^wb_dat_i[7:1];
  assign w_cnt_inc = r_cnt + 8'd1;

  always_comb begin
    w_state  = r_state;
    w_adr    = r_adr;
    w_dat    = r_dat;
    w_we     = r_we;
    w_cyc    = r_cyc;
    w_stb    = r_stb;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_err    = r_err;
    w_cnt    = r_cnt;
    w_to     = r_to;
    w_period = r_period;
    w_count  = r_count;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start_i) begin
          w_period = period_i;
          w_count  = count_i;
          w_err    = 1'b0;
          w_cnt    = 8'd0;
          if (period_i == 8'd0) begin
            w_state = ERR;
            w_err   = 1'b1;
          end else if (count_i == 8'd0) begin
            w_state = DONE;
            w_done  = 1'b1;
          end else begin
            w_state = LOAD;
            w_busy  = 1'b1;
            w_cyc   = 1'b1;
            w_stb   = 1'b1;
            w_adr   = 1'b0;
            w_we    = 1'b1;
            w_dat   = period_i;
            w_to    = 8'd0;
          end
        end
      end
      WAIT_IRQ: begin
        if (irq_i) begin
          w_state = READ;
          w_cyc   = 1'b1;
          w_stb   = 1'b1;
          w_adr   = 1'b1;
          w_we    = 1'b0;
          w_dat   = 8'h00;
          w_to    = 8'd0;
        end
      end
      LOAD, READ, CLEAR: begin
        // Strobe low on entry here means the mandatory idle cycle after the previous ack.
        if (!r_stb) begin
          w_cyc = 1'b1;
          w_stb = 1'b1;
          w_to  = 8'd0;
          w_adr = (r_state != LOAD);
          w_we  = (r_state != READ);
          w_dat = (r_state == LOAD) ? r_period : 8'h00;
        end else if (wb_ack_i) begin
          w_cyc = 1'b0;
          w_stb = 1'b0;
          case (r_state)
            LOAD:    w_state = WAIT_IRQ;
            READ:    w_state = wb_dat_i[0] ? CLEAR : WAIT_IRQ;
            default: begin
              w_cnt = w_cnt_inc;
              if (w_cnt_inc == r_count) begin
                w_state = DONE;
                w_done  = 1'b1;
                w_busy  = 1'b0;
              end else begin
                w_state = LOAD;
              end
            end
          endcase
        end else if (r_to == TO_LAST) begin
          w_state = ERR;
          w_cyc   = 1'b0;
          w_stb   = 1'b0;
          w_err   = 1'b1;
          w_busy  = 1'b0;
        end else begin
          w_to = r_to + 8'd1;
        end
      end
      DONE:    w_state = IDLE;
      ERR:     w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_adr    <= 1'b0;
      r_dat    <= 8'h00;
      r_we     <= 1'b0;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= 8'd0;
      r_to     <= 8'd0;
      r_period <= 8'd0;
      r_count  <= 8'd0;
    end else begin
      r_state  <= w_state;
      r_adr    <= w_adr;
      r_dat    <= w_dat;
      r_we     <= w_we;
      r_cyc    <= w_cyc;
      r_stb    <= w_stb;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_err    <= w_err;
      r_cnt    <= w_cnt;
      r_to     <= w_to;
      r_period <= w_period;
      r_count  <= w_count;
    end
  end

  assign wb_adr_o  = r_adr;
  assign wb_dat_o  = r_dat;
  assign wb_we_o   = r_we;
  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_stb;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign irq_cnt_o = r_cnt;

endmodule

// File: tb/tb_irq_svc_master.sv
// Bench for irq_svc_master with a behavioural interrupt-generator slave and a bus-access scoreboard.
module tb_irq_svc_master;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] period_i = 8'd0;
  logic [7:0] count_i = 8'd0;
  logic       wb_adr_o;
  logic [7:0] wb_dat_o;
  logic       wb_we_o, wb_cyc_o, wb_stb_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;
  logic       irq_i;
  logic       busy_o, done_o, err_o;
  logic [7:0] irq_cnt_o;

  always #5 clk_i = ~clk_i;

  irq_svc_master #(.TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .period_i(period_i), .count_i(count_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .irq_i(irq_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .irq_cnt_o(irq_cnt_o)
  );

  // Slave: reg0 write reloads a down-counter that raises the status bit; reg1 write sets/clears status.
  logic       ack_en = 1'b1;
  logic       irq_force = 1'b0;
  logic       s_clr = 1'b0;
  logic [7:0] s_cnt = 8'd0;
  logic       s_run = 1'b0;
  logic       s_stat = 1'b0;

  assign wb_ack_i = wb_cyc_o & wb_stb_o & ack_en;
  assign wb_dat_i = {7'b0, s_stat};
  assign irq_i    = s_stat | irq_force;

  always @(posedge clk_i) begin
    if (s_clr) begin
      s_run  <= 1'b0;
      s_stat <= 1'b0;
    end else begin
      if (wb_ack_i && wb_we_o && !wb_adr_o) begin
        s_cnt <= wb_dat_o;
        s_run <= 1'b1;
      end else if (s_run) begin
        if (s_cnt <= 8'd1) begin
          s_stat <= 1'b1;
          s_run  <= 1'b0;
        end else begin
          s_cnt <= s_cnt - 8'd1;
        end
      end
      if (wb_ack_i && wb_we_o && wb_adr_o) s_stat <= wb_dat_o[0];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard entries are {we, adr, write data (0 for reads)}.
  logic [9:0] sb[$];
  int         stb_total = 0;
  int         stb_run = 0;
  int         last_len = 0;
  int         done_cnt = 0;
  logic       p_stb = 1'b0;
  logic       p_ack = 1'b0;
  logic [9:0] p_fields = 10'd0;
  logic [9:0] cur;

  always @(negedge clk_i) begin
    cur = {wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : 8'h00};
    if (done_o) done_cnt++;
    if (wb_stb_o) begin
      stb_total++;
      stb_run++;
    end else if (stb_run != 0) begin
      last_len = stb_run;
      stb_run  = 0;
    end
    if (p_ack) check("idle_after_ack", {31'd0, wb_stb_o}, 32'd0);
    if (p_stb && !p_ack && wb_stb_o) check("hold_stable", {22'd0, cur}, {22'd0, p_fields});
    if (wb_stb_o && !wb_cyc_o) check("cyc_with_stb", {31'd0, wb_cyc_o}, 32'd1);
    if (wb_ack_i) begin
      if (sb.size() == 0) check("sb_extra_access", 32'(sb.size()), 32'd1);
      else check("sb_access", {22'd0, cur}, {22'd0, sb.pop_front()});
    end
    p_stb    = wb_stb_o;
    p_ack    = wb_ack_i;
    p_fields = cur;
  end

  task automatic push_run(input logic [7:0] p, input int c);
    for (int i = 0; i < c; i++) begin
      sb.push_back({1'b1, 1'b0, p});
      sb.push_back({1'b0, 1'b1, 8'h00});
      sb.push_back({1'b1, 1'b1, 8'h00});
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic slave_clear();
    s_clr = 1'b1;
    tick(1);
    s_clr = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] p, input logic [7:0] c);
    period_i = p;
    count_i  = c;
    start_i  = 1'b1;
    tick(1);
    start_i  = 1'b0;
  endtask

  task automatic wait_end(input int maxc);
    int n;
    n = 0;
    while (!(done_o || err_o) && n < maxc) begin
      tick(1);
      n++;
    end
    if (!(done_o || err_o)) check("end_seen", {31'd0, done_o | err_o}, 32'd1);
  endtask

  task automatic wait_sb(input int sz, input int maxc);
    int n;
    n = 0;
    while (sb.size() != sz && n < maxc) begin
      tick(1);
      n++;
    end
    if (sb.size() != sz) check("sb_level", 32'(sb.size()), 32'(sz));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int d0;
  int st0;

  initial begin
    tick(3);
    check("reset_outputs", {10'd0, wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
                            busy_o, done_o, err_o, irq_cnt_o}, 32'd0);
    rst_i = 1'b0;
    tick(2);

    // Two interrupts with period 3.
    slave_clear();
    d0 = done_cnt;
    push_run(8'd3, 2);
    do_start(8'd3, 8'd2);
    check("busy_after_start", {31'd0, busy_o}, 32'd1);
    check("stb_after_start", {31'd0, wb_stb_o}, 32'd1);
    wait_end(300);
    check("basic_done_pulse", {31'd0, done_o}, 32'd1);
    check("basic_busy_at_done", {31'd0, busy_o}, 32'd0);
    tick(2);
    check("basic_cnt", {24'd0, irq_cnt_o}, 32'd2);
    check("basic_done_count", 32'(done_cnt - d0), 32'd1);
    check("basic_err", {31'd0, err_o}, 32'd0);
    check("basic_busy_after", {31'd0, busy_o}, 32'd0);
    check("basic_sb_left", 32'(sb.size()), 32'd0);

    // Start while busy with a different period must be ignored.
    slave_clear();
    push_run(8'd6, 2);
    do_start(8'd6, 8'd2);
    tick(3);
    period_i = 8'd9;
    start_i  = 1'b1;
    tick(1);
    start_i  = 1'b0;
    wait_end(300);
    tick(2);
    check("busy_start_cnt", {24'd0, irq_cnt_o}, 32'd2);
    check("busy_start_sb_left", 32'(sb.size()), 32'd0);

    // Spurious interrupt: status reads 0, no clear, back to waiting.
    slave_clear();
    push_run(8'd20, 1);
    sb.insert(1, {1'b0, 1'b1, 8'h00});
    do_start(8'd20, 8'd1);
    wait_sb(3, 50);
    tick(2);
    irq_force = 1'b1;
    tick(1);
    irq_force = 1'b0;
    wait_sb(2, 50);
    tick(2);
    check("spur_cnt", {24'd0, irq_cnt_o}, 32'd0);
    check("spur_busy", {31'd0, busy_o}, 32'd1);
    check("spur_bus_idle", {31'd0, wb_stb_o}, 32'd0);
    wait_end(300);
    tick(2);
    check("spur_final_cnt", {24'd0, irq_cnt_o}, 32'd1);
    check("spur_sb_left", 32'(sb.size()), 32'd0);

    // Period 0 errors without bus access; count 0 completes without bus access.
    slave_clear();
    st0 = stb_total;
    d0  = done_cnt;
    do_start(8'd0, 8'd5);
    check("p0_err", {31'd0, err_o}, 32'd1);
    check("p0_busy", {31'd0, busy_o}, 32'd0);
    tick(3);
    check("p0_err_sticky", {31'd0, err_o}, 32'd1);
    check("p0_no_stb", 32'(stb_total), 32'(st0));
    do_start(8'd4, 8'd0);
    check("c0_done", {31'd0, done_o}, 32'd1);
    check("c0_err_cleared", {31'd0, err_o}, 32'd0);
    check("c0_cnt", {24'd0, irq_cnt_o}, 32'd0);
    tick(3);
    check("c0_done_once", 32'(done_cnt - d0), 32'd1);
    check("c0_no_stb", 32'(stb_total), 32'(st0));

    // No acknowledge: abort after exactly 16 strobe cycles.
    slave_clear();
    ack_en = 1'b0;
    d0 = done_cnt;
    do_start(8'd5, 8'd1);
    wait_end(100);
    tick(2);
    check("to_stb_len", 32'(last_len), 32'd16);
    check("to_err", {31'd0, err_o}, 32'd1);
    check("to_busy", {31'd0, busy_o}, 32'd0);
    check("to_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    check("to_no_done", 32'(done_cnt - d0), 32'd0);
    ack_en = 1'b1;

    // Reset while the clear write is strobing.
    slave_clear();
    d0 = done_cnt;
    sb.push_back({1'b1, 1'b0, 8'd3});
    sb.push_back({1'b0, 1'b1, 8'h00});
    do_start(8'd3, 8'd2);
    wait_sb(0, 100);
    ack_en = 1'b0;
    tick(1);
    check("clr_strobe_seen", {29'd0, wb_stb_o, wb_we_o, wb_adr_o}, 32'd7);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    check("rst_mid_outputs", {10'd0, wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
                              busy_o, done_o, err_o, irq_cnt_o}, 32'd0);
    st0 = stb_total;
    tick(5);
    check("rst_no_bus", 32'(stb_total), 32'(st0));
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    ack_en = 1'b1;
    slave_clear();
    push_run(8'd3, 1);
    do_start(8'd3, 8'd1);
    wait_end(300);
    tick(2);
    check("post_rst_cnt", {24'd0, irq_cnt_o}, 32'd1);
    check("post_rst_done", 32'(done_cnt - d0), 32'd1);
    check("post_rst_err", {31'd0, err_o}, 32'd0);
    check("post_rst_sb_left", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_svc_master.md
IRQ_SVC_MASTER -- requirements
Module: irq_svc_master

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles stb may wait for ack before abort (range 1..255).
REQ-002 clk_i  in  1  sole clock; all logic on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 start_i  in  1  begin service run; sampled only in IDLE.
REQ-005 period_i  in  8  counter reload value written to slave reg 0; captured on start.
REQ-006 count_i  in  8  number of interrupts to service; captured on start.
REQ-007 wb_adr_o  out  1  Wishbone address (0 = counter reg, 1 = irq status/clear reg).
REQ-008 wb_dat_o  out  8  Wishbone write data.
REQ-009 wb_we_o  out  1  Wishbone write enable.
REQ-010 wb_cyc_o  out  1  Wishbone cycle.
REQ-011 wb_stb_o  out  1  Wishbone strobe.
REQ-012 wb_dat_i  in  8  Wishbone read data.
REQ-013 wb_ack_i  in  1  Wishbone acknowledge (may be combinational from stb & cyc).
REQ-014 irq_i  in  1  level interrupt from slave.
REQ-015 busy_o  out  1  high from the cycle after accepted start until run ends.
REQ-016 done_o  out  1  one-cycle pulse on successful completion.
REQ-017 err_o  out  1  sticky error flag; cleared by the next accepted start or reset.
REQ-018 irq_cnt_o  out  8  interrupts serviced (cleared) in current/last run.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 States SHALL be IDLE, LOAD, WAIT_IRQ, READ, CLEAR, DONE, ERR.
REQ-021 Bus access SHALL be classic single-beat: cyc, stb, adr, we, dat asserted together and held stable until ack_i is sampled high; cyc and stb SHALL be low in the cycle after ack; at least one idle cycle SHALL separate accesses.
REQ-022 IDLE + start_i: capture inputs, clear err_o and irq_cnt_o; period 0 -> ERR (no bus access); count 0 -> DONE (no bus access); otherwise -> LOAD, stb high in the cycle after start.
REQ-023 LOAD: write period to adr 0; on ack -> WAIT_IRQ.
REQ-024 WAIT_IRQ: no bus activity; irq_i sampled high -> READ.
REQ-025 READ: read adr 1 (we low); on ack, wb_dat_i[0]=1 -> CLEAR; wb_dat_i[0]=0 (spurious) -> WAIT_IRQ, no count increment.
REQ-026 CLEAR: write 8'h00 to adr 1; on ack increment irq_cnt_o; if irq_cnt_o+1 == count -> DONE else -> LOAD.
REQ-027 DONE: done_o high exactly one cycle, busy_o low the same cycle, -> IDLE.
REQ-028 Timeout: a cycle counter SHALL count cycles with stb high and ack low; when it reaches TIMEOUT -> ERR, cyc/stb dropped next cycle; counter cleared at each new access.
REQ-029 ERR: set err_o, busy_o low, no done_o pulse, -> IDLE in one cycle.
REQ-030 start_i while busy SHALL be ignored; irq_i outside WAIT_IRQ SHALL be ignored.
REQ-031 irq_cnt_o SHALL not wrap (count_i <= 255 bounds it).

Reset
REQ-032 rst_i high at a clock edge SHALL force IDLE and all outputs to 0 (wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, busy_o, done_o, err_o, irq_cnt_o) at that edge, including mid-bus-cycle; no further bus activity until a new start.

Verification (bench with the team's 8-bit Wishbone interrupt-generator slave attached)
REQ-033 start, period 3, count 2 -> write 0x03@0, wait, read 0x01@1, write 0x00@1, repeat; irq_cnt_o=2, one done_o pulse, err_o=0, busy_o low afterwards.
REQ-034 wb_ack_i tied 0, start period 5 count 1 -> stb high exactly TIMEOUT=16 cycles, then cyc/stb low, err_o=1, busy_o=0, no done_o.
REQ-035 start period 0 -> err_o=1, no stb asserted; start count 0 period 4 -> done_o pulse, no stb, irq_cnt_o=0.
REQ-036 Forced irq_i pulse with slave status reading 0x00 -> READ access only, no clear write, irq_cnt_o unchanged, back to WAIT_IRQ.
REQ-037 rst_i asserted during CLEAR with stb high -> next edge all outputs 0, state IDLE; later start runs normally.
REQ-038 start_i pulsed while busy with different period -> ignored; bus writes keep original period.
